// File: rtl/pool_sched_pkg.sv
// pool_sched_pkg: shared state encoding and stride/width helpers for the pooling layer scheduler
package pool_sched_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, NEXT, FINISH, ERROR} state_t;
  function automatic int in_stride(int h, int w);
    return h * w;
  endfunction
  function automatic int out_stride(int h, int w);
    return (h / 2) * (w / 2);
  endfunction
  function automatic int cnt_w(int t);
    return t > 2 ? $clog2(t) : 1;
  endfunction
endpackage

// File: rtl/sched_watchdog.sv
// sched_watchdog: clearable up-counter flagging expiry at TIMEOUT-1
module sched_watchdog import pool_sched_pkg::*; #(
  parameter int TIMEOUT = 4096,
  localparam int CW = cnt_w(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= (rst || clr) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  assign expired = cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/pool_layer_sched.sv
// pool_layer_sched: sequences a multi-channel max-pool layer one channel per pipeline pass
module pool_layer_sched import pool_sched_pkg::*; #(
  parameter int H       = 6,
  parameter int W       = 6,
  parameter int CH_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [CH_W-1:0]   cfg_channels,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic              abort,
  input  logic              irq_clr,
  input  logic              pool_done,
  output logic              pool_start,
  output logic [ADDR_W-1:0] pool_in_base,
  output logic [ADDR_W-1:0] pool_out_base,
  output logic [CH_W-1:0]   ch_idx,
  output logic              busy,
  output logic              done,
  output logic              irq,
  output logic              err_timeout
);
  localparam logic [ADDR_W-1:0] IN_S  = ADDR_W'(in_stride(H, W));
  localparam logic [ADDR_W-1:0] OUT_S = ADDR_W'(out_stride(H, W));
  state_t            st_q, st_d;
  logic              done_q, irq_q, err_q, expired, done_edge;
  logic [CH_W-1:0]   ch_q, chn_q;
  logic [ADDR_W-1:0] in_q, out_q;
  assign done_edge = pool_done & ~done_q;
  sched_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (st_q == LAUNCH),
    .en      (st_q == WAIT),
    .expired (expired)
  );
  always_comb begin
    st_d = abort             ? IDLE :
           st_q == IDLE      ? (cfg_start ? (cfg_channels == '0 ? FINISH : LAUNCH) : IDLE) :
           st_q == LAUNCH    ? WAIT :
           st_q == WAIT      ? (done_edge ? NEXT : expired ? ERROR : WAIT) :
           st_q == NEXT      ? (ch_q == chn_q - 1'b1 ? FINISH : LAUNCH) :
                               IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      done_q <= 1'b0;
      irq_q  <= 1'b0;
      err_q  <= 1'b0;
      ch_q   <= '0;
      chn_q  <= '0;
      in_q   <= '0;
      out_q  <= '0;
    end else begin
      st_q   <= st_d;
      done_q <= pool_done;
      irq_q  <= (st_q == FINISH && !abort) | (irq_q & ~irq_clr);
      if (!abort) begin
        if (st_q == IDLE && cfg_start) begin
          chn_q <= cfg_channels;
          in_q  <= cfg_in_base;
          out_q <= cfg_out_base;
          ch_q  <= '0;
          err_q <= 1'b0;
        end
        if (st_q == ERROR) err_q <= 1'b1;
        if (st_q == NEXT && st_d == LAUNCH) begin
          ch_q  <= ch_q + 1'b1;
          in_q  <= in_q + IN_S;
          out_q <= out_q + OUT_S;
        end
      end
    end
  end
  assign pool_start    = st_q == LAUNCH;
  assign done          = st_q == FINISH;
  assign busy          = st_q != IDLE;
  assign pool_in_base  = in_q;
  assign pool_out_base = out_q;
  assign ch_idx        = ch_q;
  assign irq           = irq_q;
  assign err_timeout   = err_q;
endmodule
